// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
//
// UART transmitter. Takes one parallel word per frame through a valid/busy
// handshake and shifts it out one bit per CLK cycle as: start bit (0),
// DATA_WIDTH data bits LSB first, optional parity bit, stop bit (1).
// CLK is the TX bit clock, so every cycle is one bit time on the line.
//
// Ports
//   CLK         in   1           TX bit clock, all state on the rising edge
//   RST         in   1           asynchronous reset, active low
//   P_DATA      in   DATA_WIDTH  parallel word to send
//   Data_Valid  in   1           P_DATA valid; taken only in IDLE (busy==0)
//   PAR_EN      in   1           1: append a parity bit
//   PAR_TYP     in   1           0: even parity, 1: odd parity
//   TX_OUT      out  1           serial line, straight from a flop, idle high
//   busy        out  1           registered, high while a frame is in flight
// -----------------------------------------------------------------------------
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
    logic [DATA_WIDTH-1:0] data_q, data_next;
    logic                  par_en_q, par_en_next;
    logic                  par_bit_q, par_bit_next;
    logic                  tx_next, busy_next;

    // State and output register. TX_OUT and busy are computed one cycle ahead
    // in the next-state logic so the pin sees only a flop output.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            data_q    <= data_next;
            par_en_q  <= par_en_next;
            par_bit_q <= par_bit_next;
            TX_OUT    <= tx_next;
            busy      <= busy_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_next   = state;
        bit_cnt_next = bit_cnt;
        data_next    = data_q;
        par_en_next  = par_en_q;
        par_bit_next = par_bit_q;
        tx_next      = TX_OUT;
        busy_next    = busy;

        case (state)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (Data_Valid) begin
                    // Parity is resolved at accept time, so later changes on
                    // P_DATA or PAR_TYP cannot reach this frame.
                    data_next    = P_DATA;
                    par_en_next  = PAR_EN;
                    par_bit_next = (^P_DATA) ^ PAR_TYP;
                    state_next   = START;
                    tx_next      = 1'b0;
                    busy_next    = 1'b1;
                end
            end
            START: begin
                state_next   = DATA;
                bit_cnt_next = '0;
                tx_next      = data_q[0];
            end
            DATA: begin
                // bit_cnt names the bit currently on the line; the flop is
                // loaded with the bit for the coming cycle.
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_next = '0;
                    if (par_en_q) begin
                        state_next = PARITY;
                        tx_next    = par_bit_q;
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                    tx_next      = data_q[bit_cnt_next];
                end
            end
            PARITY: begin
                state_next = STOP;
                tx_next    = 1'b1;
            end
            STOP: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_core.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_core
//
// Directed bench for uart_tx_core (DATA_WIDTH = 8). Single frames come from a
// table of hand-computed line patterns; back-to-back frames, mid-frame reset
// and parity-setting churn are separate sequences. Outputs are sampled on the
// falling edge, inputs are driven on the falling edge.
//
// Line patterns are 11 bits, bit 10 = first cycle after the accept edge:
// start, d0..d7, parity (or stop), stop (or idle).
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [10:0] bits;
        int          busy_len;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launches one frame and records 11 line samples plus busy over 12 cycles.
    task automatic run_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [10:0] exp_bits,
                             input int exp_len, input bit churn);
        logic [10:0] got;
        int          bcnt;
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(posedge CLK);
        got  = '0;
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (i < 11) got[10-i] = TX_OUT;
            if (busy) bcnt++;
            if (i == 0) Data_Valid = 1'b0;
            if (churn) begin
                PAR_EN  = ~PAR_EN;
                PAR_TYP = ~PAR_TYP;
                P_DATA  = ~P_DATA;
            end
        end
        check({name, " line"}, 32'(got), 32'(exp_bits));
        check({name, " busy_len"}, bcnt, exp_len);
    endtask

    initial begin
        logic [35:0] stream;

        vecs[0] = '{"a5_even", 8'hA5, 1'b1, 1'b0, 11'b0_10100101_0_1, 11};
        vecs[1] = '{"03_odd",  8'h03, 1'b1, 1'b1, 11'b0_11000000_1_1, 11};
        vecs[2] = '{"ff_nopar",8'hFF, 1'b0, 1'b0, 11'b0_11111111_1_1, 10};
        vecs[3] = '{"00_even", 8'h00, 1'b1, 1'b0, 11'b0_00000000_0_1, 11};
        vecs[4] = '{"00_odd",  8'h00, 1'b1, 1'b1, 11'b0_00000000_1_1, 11};
        vecs[5] = '{"80_nopar",8'h80, 1'b0, 1'b1, 11'b0_00000001_1_1, 10};
        vecs[6] = '{"01_even", 8'h01, 1'b1, 1'b0, 11'b0_10000000_1_1, 11};
        vecs[7] = '{"5a_odd",  8'h5A, 1'b1, 1'b1, 11'b0_01011010_1_1, 11};

        RST        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("reset tx", 32'(TX_OUT), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle tx", 32'(TX_OUT), 32'd1);

        // Single frames from the table
        for (int v = 0; v < 8; v++)
            run_frame(vecs[v].name, vecs[v].data, vecs[v].par_en, vecs[v].par_typ,
                      vecs[v].bits, vecs[v].busy_len, 1'b0);

        // Data_Valid held for three frames, P_DATA moved mid-frame: each frame
        // carries the byte present at its accept edge, 1 idle bit in between.
        @(negedge CLK);
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(posedge CLK);
        stream = '0;
        for (int i = 0; i < 36; i++) begin
            @(negedge CLK);
            stream[35-i] = TX_OUT;
            if (i == 5)  P_DATA = 8'h00;
            if (i == 17) P_DATA = 8'h01;
            if (i == 24) Data_Valid = 1'b0;
        end
        check("b2b frame0", 32'(stream[35:24]), 32'({11'b0_10100101_0_1, 1'b1}));
        check("b2b frame1", 32'(stream[23:12]), 32'({11'b0_00000000_0_1, 1'b1}));
        check("b2b frame2", 32'(stream[11:0]),  32'({11'b0_10000000_1_1, 1'b1}));

        // Reset during data bit 4 of 0x5A, then a clean 0x3C frame
        @(negedge CLK);
        P_DATA     = 8'h5A;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 0) Data_Valid = 1'b0;
        end
        check("mid busy", 32'(busy), 32'd1);
        #2 RST = 1'b0;
        #1;
        check("async rst tx", 32'(TX_OUT), 32'd1);
        check("async rst busy", 32'(busy), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        check("held rst busy", 32'(busy), 32'd0);
        RST = 1'b1;
        run_frame("3c_after_rst", 8'h3C, 1'b1, 1'b0, 11'b0_00111100_0_1, 11, 1'b0);

        // Parity settings and data churned every cycle after accept
        run_frame("a5_churn", 8'hA5, 1'b1, 1'b0, 11'b0_10100101_0_1, 11, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
